pipeline_stage_controller: RTL and testbench

PIPELINE_STAGE_CONTROLLER -- requirements
Module: pipeline_stage_controller

---
 rtl/pipe_ctrl_pkg.sv | 33 +++
 rtl/pipeline_stage_controller_if.sv | 13 +
 rtl/mem_wait_fsm.sv | 67 ++++++
 rtl/pipeline_stage_controller.sv | 97 +++++++++
 tb/tb_pipeline_stage_controller.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stage controller and its
// data-memory wait FSM.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR  = 2'd2
  } mem_state_t;

  localparam int MEM_TIMEOUT_DEFAULT = 15;

  typedef struct packed {
    logic pc_we;
    logic ifid_we;
    logic idex_we;
    logic exmem_we;
    logic memwb_we;
    logic ifid_flush;
    logic idex_bubble;
  } stage_ctrl_t;

  localparam stage_ctrl_t CTRL_HOLD  = stage_ctrl_t'(7'b0000000);
  localparam stage_ctrl_t CTRL_RUN   = stage_ctrl_t'(7'b1111100);
  localparam stage_ctrl_t CTRL_STALL = stage_ctrl_t'(7'b0011101);
  localparam stage_ctrl_t CTRL_KILL  = stage_ctrl_t'(7'b1111110);

  // Wide enough to hold MEM_TIMEOUT itself, so the counter can saturate.
  function automatic int wait_cnt_width(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/pipeline_stage_controller_if.sv
// Data-memory handshake link between the stage controller and the wait FSM.
interface pipeline_stage_controller_if;
  logic req_valid;
  logic dmem_ack;
  logic dmem_req;
  logic freeze;
  logic mem_err;

  modport master (output req_valid, output dmem_ack,
                  input  dmem_req, input freeze, input mem_err);
  modport slave  (input  req_valid, input dmem_ack,
                  output dmem_req, output freeze, output mem_err);
endinterface

// File: rtl/mem_wait_fsm.sv
// Tracks data-memory wait states, freezes the pipeline while an access is
// outstanding and latches a sticky error when the wait exceeds MEM_TIMEOUT.
module mem_wait_fsm
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
  input logic                        clk,
  input logic                        reset_n,
  pipeline_stage_controller_if.slave link
);

  localparam int WCNT_W = wait_cnt_width(MEM_TIMEOUT);
  localparam logic [WCNT_W-1:0] CNT_MAX  = WCNT_W'(MEM_TIMEOUT);
  localparam logic [WCNT_W-1:0] CNT_LAST = WCNT_W'(MEM_TIMEOUT - 1);

  mem_state_t        state_reg, state_next;
  logic [WCNT_W-1:0] cnt_reg, cnt_next;
  logic              err_reg, err_next;
  logic              req;

  assign req = reset_n & link.req_valid & ~err_reg &
               ((state_reg == ST_IDLE) | (state_reg == ST_WAIT));

  assign link.dmem_req = req;
  assign link.freeze   = err_reg | (req & ~link.dmem_ack);
  assign link.mem_err  = err_reg;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    err_next   = err_reg;
    case (state_reg)
      ST_IDLE: begin
        cnt_next = '0;
        if (req && !link.dmem_ack) state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (link.dmem_ack) begin
          state_next = ST_IDLE;
        end else begin
          if (cnt_reg != CNT_MAX) cnt_next = cnt_reg + WCNT_W'(1);
          // This WAIT cycle brings the count to MEM_TIMEOUT: give up.
          if (cnt_reg == CNT_LAST) begin
            state_next = ST_ERR;
            err_next   = 1'b1;
          end
        end
      end
      ST_ERR:  state_next = ST_ERR;
      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/pipeline_stage_controller.sv
// Five-stage pipeline controller: write enables, flush/bubble, per-stage
// valids, data-memory request handshake and a retired-instruction counter.
module pipeline_stage_controller
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             hazard_stall,
  input  logic             kill,
  input  logic             ex_mem_op,
  input  logic             dmem_ack,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             idex_we,
  output logic             exmem_we,
  output logic             memwb_we,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             valid_id,
  output logic             valid_ex,
  output logic             valid_mem,
  output logic             valid_wb,
  output logic             dmem_req,
  output logic             mem_err,
  output logic [CNT_W-1:0] retired
);

  pipeline_stage_controller_if link();

  // Stage index: 0=ID, 1=EX, 2=MEM, 3=WB.
  logic [3:0]       valid_reg, valid_next;
  logic             mem_op_mem_reg;
  logic [CNT_W-1:0] retired_reg;
  logic             freeze;
  stage_ctrl_t      ctrl;

  assign link.req_valid = valid_reg[2] & mem_op_mem_reg;
  assign link.dmem_ack  = dmem_ack;
  assign freeze         = link.freeze;

  mem_wait_fsm #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_fsm (
    .clk     (clk),
    .reset_n (reset_n),
    .link    (link)
  );

  always_comb begin
    ctrl = CTRL_HOLD;
    if (reset_n && !freeze) begin
      if (hazard_stall)  ctrl = CTRL_STALL;
      else if (kill)     ctrl = CTRL_KILL;
      else               ctrl = CTRL_RUN;
    end
  end

  // Next valids for an unfrozen cycle; a stall keeps ID and bubbles EX.
  for (genvar gi = 0; gi < 4; gi++) begin : g_valid
    if (gi == 0) begin : g_id
      assign valid_next[gi] = hazard_stall ? valid_reg[0] : ~kill;
    end else if (gi == 1) begin : g_ex
      assign valid_next[gi] = ~hazard_stall & valid_reg[0];
    end else begin : g_tail
      assign valid_next[gi] = valid_reg[gi-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_reg      <= '0;
      mem_op_mem_reg <= 1'b0;
      retired_reg    <= '0;
    end else if (!freeze) begin
      valid_reg      <= valid_next;
      mem_op_mem_reg <= ex_mem_op;
      if (valid_reg[3]) retired_reg <= retired_reg + CNT_W'(1);
    end
  end

  assign pc_we       = ctrl.pc_we;
  assign ifid_we     = ctrl.ifid_we;
  assign idex_we     = ctrl.idex_we;
  assign exmem_we    = ctrl.exmem_we;
  assign memwb_we    = ctrl.memwb_we;
  assign ifid_flush  = ctrl.ifid_flush;
  assign idex_bubble = ctrl.idex_bubble;
  assign valid_id    = valid_reg[0];
  assign valid_ex    = valid_reg[1];
  assign valid_mem   = valid_reg[2];
  assign valid_wb    = valid_reg[3];
  assign dmem_req    = link.dmem_req;
  assign mem_err     = link.mem_err;
  assign retired     = retired_reg;

endmodule

// File: tb/tb_pipeline_stage_controller.sv
// Scenario and randomized checks of pipeline_stage_controller against a
// cycle-level behavioural model of the pipeline.
module tb_pipeline_stage_controller;
  import pipe_ctrl_pkg::*;

  localparam int CNT_W = 8;
  localparam int TMO   = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n, hazard_stall, kill, ex_mem_op;
  logic pc_we, ifid_we, idex_we, exmem_we, memwb_we, ifid_flush, idex_bubble;
  logic valid_id, valid_ex, valid_mem, valid_wb;
  logic [CNT_W-1:0] retired;

  pipeline_stage_controller_if tb_bus();

  pipeline_stage_controller #(.MEM_TIMEOUT(TMO), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .hazard_stall(hazard_stall), .kill(kill),
    .ex_mem_op(ex_mem_op), .dmem_ack(tb_bus.dmem_ack),
    .pc_we(pc_we), .ifid_we(ifid_we), .idex_we(idex_we), .exmem_we(exmem_we),
    .memwb_we(memwb_we), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .valid_id(valid_id), .valid_ex(valid_ex), .valid_mem(valid_mem),
    .valid_wb(valid_wb), .dmem_req(tb_bus.dmem_req), .mem_err(tb_bus.mem_err),
    .retired(retired)
  );

  wire [7:0] obs_ctrl = {pc_we, ifid_we, idex_we, exmem_we, memwb_we,
                         ifid_flush, idex_bubble, tb_bus.dmem_req};
  wire [3:0] obs_vld  = {valid_id, valid_ex, valid_mem, valid_wb};

  int checks = 0;
  int errors = 0;

  // Model: stage occupancy, load flag in MEM, error flag, count of
  // consecutive unanswered request cycles, retired count.
  bit [3:0] m_vld;
  bit       m_op, m_err;
  int       m_miss, m_ret;

  function automatic bit m_req();
    return (reset_n === 1'b1) && m_vld[2] && m_op && !m_err;
  endfunction

  function automatic bit m_frz();
    return m_err || (m_req() && (tb_bus.dmem_ack !== 1'b1));
  endfunction

  function automatic logic [7:0] exp_ctrl();
    if (reset_n !== 1'b1) return 8'h00;
    if (m_frz())          return {7'b0000000, m_req()};
    if (hazard_stall)     return {7'b0011101, m_req()};
    if (kill)             return {7'b1111110, m_req()};
    return {7'b1111100, m_req()};
  endfunction

  function automatic logic [3:0] exp_vld();
    return {m_vld[0], m_vld[1], m_vld[2], m_vld[3]};
  endfunction

  task automatic drive(input bit r, input bit hs, input bit kl,
                       input bit op, input bit ack);
    reset_n = r; hazard_stall = hs; kill = kl; ex_mem_op = op;
    tb_bus.dmem_ack = ack;
    #2;
  endtask

  // Advance model by one clock using the current inputs, then clock the DUT.
  task automatic tick();
    bit req, frz;
    req = m_req();
    frz = m_frz();
    if (reset_n !== 1'b1) begin
      m_vld = '0; m_op = 0; m_err = 0; m_miss = 0; m_ret = 0;
    end else if (frz) begin
      if (req && !tb_bus.dmem_ack) begin
        m_miss++;
        if (m_miss == TMO + 1) m_err = 1;
      end
    end else begin
      m_miss = 0;
      if (m_vld[3]) m_ret = (m_ret + 1) % (1 << CNT_W);
      m_vld[3] = m_vld[2];
      m_vld[2] = m_vld[1];
      if (hazard_stall) begin
        m_vld[1] = 0;
      end else if (kill) begin
        m_vld[1] = m_vld[0];
        m_vld[0] = 0;
      end else begin
        m_vld[1] = m_vld[0];
        m_vld[0] = 1;
      end
      m_op = ex_mem_op;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 0, 0);
    if (obs_ctrl !== 8'h00) begin errors++; $display("FAIL reset_ctrl got %b want %b", obs_ctrl, 8'h00); end
    checks++;
    tick(); tick();
    drive(0, 1, 1, 1, 1);
    if (obs_ctrl !== exp_ctrl()) begin errors++; $display("FAIL reset_ctrl_held got %b want %b", obs_ctrl, exp_ctrl()); end
    checks++;
    if (obs_vld !== 4'b0000) begin errors++; $display("FAIL reset_valids got %b want 0000", obs_vld); end
    checks++;
    if (tb_bus.mem_err !== 1'b0) begin errors++; $display("FAIL reset_mem_err got %b want 0", tb_bus.mem_err); end
    checks++;
    if (retired !== '0) begin errors++; $display("FAIL reset_retired got %0d want 0", retired); end
    checks++;
    tick();
  endtask

  task automatic test_fill();
    for (int c = 1; c <= 7; c++) begin
      drive(1, 0, 0, 0, 0);
      if (obs_ctrl !== exp_ctrl()) begin errors++; $display("FAIL fill_ctrl c%0d got %b want %b", c, obs_ctrl, exp_ctrl()); end
      checks++;
      tick();
      if (c == 1 && valid_id !== 1'b1) begin errors++; $display("FAIL fill_valid_id got %b want 1", valid_id); end
      if (c == 1) checks++;
      if (c == 4 && obs_vld !== 4'b1111) begin errors++; $display("FAIL fill_valids got %b want 1111", obs_vld); end
      if (c == 4) checks++;
    end
    if (retired !== CNT_W'(3)) begin errors++; $display("FAIL fill_retired got %0d want 3", retired); end
    checks++;
  endtask

  task automatic test_stall();
    drive(1, 1, 0, 0, 0);
    if (obs_ctrl !== 8'b00111010) begin errors++; $display("FAIL stall_ctrl got %b want 00111010", obs_ctrl); end
    checks++;
    tick();
    if (valid_ex !== 1'b0 || valid_mem !== 1'b1) begin
      errors++; $display("FAIL stall_valids got ex=%b mem=%b want ex=0 mem=1", valid_ex, valid_mem);
    end
    checks++;
    if (obs_vld !== exp_vld()) begin errors++; $display("FAIL stall_model got %b want %b", obs_vld, exp_vld()); end
    checks++;
  endtask

  task automatic test_kill_stall();
    drive(1, 1, 1, 0, 0);
    if (obs_ctrl !== 8'b00111010) begin errors++; $display("FAIL killstall_ctrl got %b want 00111010", obs_ctrl); end
    checks++;
    tick();
    drive(1, 0, 1, 0, 0);
    if (obs_ctrl !== 8'b11111100) begin errors++; $display("FAIL kill_ctrl got %b want 11111100", obs_ctrl); end
    checks++;
    tick();
    if (valid_id !== 1'b0) begin errors++; $display("FAIL kill_valid_id got %b want 0", valid_id); end
    checks++;
    if (obs_vld !== exp_vld()) begin errors++; $display("FAIL kill_model got %b want %b", obs_vld, exp_vld()); end
    checks++;
  endtask

  task automatic test_mem_wait();
    drive(0, 0, 0, 0, 0); tick();
    drive(1, 0, 0, 0, 0); tick(); tick();
    drive(1, 0, 0, 1, 0); tick();
    for (int k = 0; k < 4; k++) begin
      drive(1, 0, 0, 0, k == 3);
      if (tb_bus.dmem_req !== 1'b1) begin errors++; $display("FAIL wait_req k%0d got %b want 1", k, tb_bus.dmem_req); end
      checks++;
      if (obs_ctrl[7:3] !== ((k == 3) ? 5'b11111 : 5'b00000)) begin
        errors++; $display("FAIL wait_we k%0d got %b want %b", k, obs_ctrl[7:3], (k == 3) ? 5'b11111 : 5'b00000);
      end
      checks++;
      tick();
    end
    if (dut.u_fsm.state_reg !== ST_IDLE) begin errors++; $display("FAIL wait_state got %0d want %0d", dut.u_fsm.state_reg, ST_IDLE); end
    checks++;
    drive(1, 0, 0, 0, 0);
    if (obs_ctrl !== exp_ctrl()) begin errors++; $display("FAIL wait_after got %b want %b", obs_ctrl, exp_ctrl()); end
    checks++;
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive((i == 0) ? 1'b0 : ($urandom_range(0, 39) != 0),
            $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
            $urandom_range(0, 2) == 0, $urandom_range(0, 9) < 7);
      if (obs_ctrl !== exp_ctrl()) begin errors++; $display("FAIL rand_ctrl i%0d got %b want %b", i, obs_ctrl, exp_ctrl()); end
      checks++;
      if (obs_vld !== exp_vld()) begin errors++; $display("FAIL rand_valids i%0d got %b want %b", i, obs_vld, exp_vld()); end
      checks++;
      if (tb_bus.mem_err !== m_err) begin errors++; $display("FAIL rand_mem_err i%0d got %b want %b", i, tb_bus.mem_err, m_err); end
      checks++;
      if (retired !== CNT_W'(m_ret)) begin errors++; $display("FAIL rand_retired i%0d got %0d want %0d", i, retired, m_ret); end
      checks++;
      tick();
    end
  endtask

  task automatic test_timeout();
    int r0;
    drive(0, 0, 0, 0, 0); tick();
    drive(1, 0, 0, 0, 0);
    repeat (5) tick();
    drive(1, 0, 0, 1, 0); tick();
    for (int k = 1; k <= TMO + 1; k++) begin
      drive(1, $urandom_range(0, 1), $urandom_range(0, 1), 0, 0);
      if (obs_ctrl !== 8'h01) begin errors++; $display("FAIL tmo_ctrl k%0d got %b want 00000001", k, obs_ctrl); end
      checks++;
      tick();
      if (tb_bus.mem_err !== (k == TMO + 1)) begin
        errors++; $display("FAIL tmo_mem_err k%0d got %b want %b", k, tb_bus.mem_err, k == TMO + 1);
      end
      checks++;
    end
    r0 = m_ret;
    for (int k = 0; k < 8; k++) begin
      drive(1, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
      if (obs_ctrl !== 8'h00) begin errors++; $display("FAIL err_ctrl k%0d got %b want 00000000", k, obs_ctrl); end
      checks++;
      tick();
      if (retired !== CNT_W'(r0) || obs_vld !== exp_vld()) begin
        errors++; $display("FAIL err_hold k%0d got ret=%0d vld=%b want ret=%0d vld=%b", k, retired, obs_vld, r0, exp_vld());
      end
      checks++;
    end
    drive(0, 0, 0, 0, 0); tick();
    if (tb_bus.mem_err !== 1'b0) begin errors++; $display("FAIL err_reset got %b want 0", tb_bus.mem_err); end
    checks++;
    drive(1, 0, 0, 0, 0);
    if (tb_bus.dmem_req !== 1'b0) begin errors++; $display("FAIL err_reset_req got %b want 0", tb_bus.dmem_req); end
    checks++;
    tick();
  endtask

  task automatic test_wrap();
    int n;
    drive(0, 0, 0, 0, 0); tick();
    drive(1, 0, 0, 0, 0);
    n = 0;
    while (m_ret != (1 << CNT_W) - 2 && n < 400) begin tick(); n++; end
    if (n >= 400) begin errors++; $display("FAIL wrap_bound got %0d cycles want < 400", n); end
    checks++;
    if (retired !== CNT_W'(m_ret)) begin errors++; $display("FAIL wrap_pre got %0d want %0d", retired, m_ret); end
    checks++;
    tick();
    if (retired !== {CNT_W{1'b1}}) begin errors++; $display("FAIL wrap_ones got %h want %h", retired, {CNT_W{1'b1}}); end
    checks++;
    tick();
    if (retired !== CNT_W'(0)) begin errors++; $display("FAIL wrap_zero got %h want 0", retired); end
    checks++;
    tick();
    if (retired !== CNT_W'(1)) begin errors++; $display("FAIL wrap_one got %h want 1", retired); end
    checks++;
  endtask

  initial begin
    m_vld = '0; m_op = 0; m_err = 0; m_miss = 0; m_ret = 0;
    test_reset();
    test_fill();
    test_stall();
    test_kill_stall();
    test_mem_wait();
    test_random();
    test_timeout();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
